// File: rtl/czonotope_reader.sv
// Streams a stored constrained zonotope (c, G, A, b) out of four sync-read RAMs
// as a tagged valid/ready beat sequence, through a 2-entry output buffer.
module czonotope_reader #(
    parameter int unsigned NMAX       = 3,
    parameter int unsigned NGMAX      = 15,
    parameter int unsigned NCMAX      = 12,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned N_W  = $clog2(NMAX + 1),
    localparam int unsigned NG_W = $clog2(NGMAX + 1),
    localparam int unsigned NC_W = $clog2(NCMAX + 1),
    localparam int unsigned CR_W = (NMAX > 1) ? $clog2(NMAX) : 1,
    localparam int unsigned GC_W = (NGMAX > 1) ? $clog2(NGMAX) : 1,
    localparam int unsigned AR_W = (NCMAX > 1) ? $clog2(NCMAX) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [N_W-1:0]        n_i,
    input  logic [NG_W-1:0]       ng_i,
    input  logic [NC_W-1:0]       nc_i,
    output logic [CR_W-1:0]       c_addr,
    input  logic [DATA_WIDTH-1:0] c_rdata,
    output logic [CR_W-1:0]       G_raddr,
    output logic [GC_W-1:0]       G_caddr,
    input  logic [DATA_WIDTH-1:0] G_rdata,
    output logic [AR_W-1:0]       A_raddr,
    output logic [GC_W-1:0]       A_caddr,
    input  logic [DATA_WIDTH-1:0] A_rdata,
    output logic [AR_W-1:0]       b_addr,
    input  logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            m_field,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned ROW_W = (N_W > NC_W) ? N_W : NC_W;

    typedef enum logic [2:0] {IDLE, RD_C, RD_G, RD_A, RD_B, DRAIN} state_t;

    state_t                state_q, state_n, nxt_sec_c, first_c;
    logic [ROW_W-1:0]      r_q, r_n, row_lim_c;
    logic [NG_W-1:0]       k_q, k_n;
    logic [N_W-1:0]        n_q;
    logic [NG_W-1:0]       ng_q;
    logic [NC_W-1:0]       nc_q;
    logic                  rd_q, rd_last_q;
    logic [1:0]            rd_field_q, sec_field_c;
    logic [1:0]            buf_cnt_q, buf_cnt_n, cnt_pop_c;
    logic [2:0]            occ_c;
    logic [DATA_WIDTH-1:0] sk_data_q, in_data_c;
    logic [1:0]            sk_field_q;
    logic                  sk_last_q;
    logic                  pop_c, in_sec_c, issue_c, row_end_c, col_end_c, sec_end_c;
    logic                  accept_c, last_hs_c;

    // Next non-empty section after s; IDLE yields the first one, DRAIN means none left.
    function automatic state_t sec_after(input state_t s, input logic hc, input logic hg,
                                         input logic ha, input logic hb);
        sec_after = DRAIN;
        if (hb && s != RD_B) sec_after = RD_B;
        if (ha && (s == IDLE || s == RD_C || s == RD_G)) sec_after = RD_A;
        if (hg && (s == IDLE || s == RD_C)) sec_after = RD_G;
        if (hc && s == IDLE) sec_after = RD_C;
    endfunction

    always_comb begin
        pop_c     = m_valid && m_ready;
        last_hs_c = pop_c && m_last;
        // Entries held after this edge: buffered minus pop plus the read landing now.
        occ_c     = 3'(buf_cnt_q) + 3'(rd_q) - 3'(pop_c);
        buf_cnt_n = 2'(occ_c);
        cnt_pop_c = 2'(buf_cnt_q - 2'(pop_c));
        in_sec_c  = (state_q == RD_C) || (state_q == RD_G) ||
                    (state_q == RD_A) || (state_q == RD_B);
        issue_c   = in_sec_c && (occ_c < 3'd2);
        row_lim_c = (state_q == RD_C || state_q == RD_G) ? ROW_W'(n_q) : ROW_W'(nc_q);
        row_end_c = (ROW_W'(r_q + 1'b1) == row_lim_c);
        col_end_c = (NG_W'(k_q + 1'b1) == ng_q);
        sec_end_c = row_end_c && (state_q == RD_C || state_q == RD_B || col_end_c);
        nxt_sec_c = sec_after(state_q, n_q != '0, (n_q != '0) && (ng_q != '0),
                              (nc_q != '0) && (ng_q != '0), nc_q != '0);
        first_c   = sec_after(IDLE, n_i != '0, (n_i != '0) && (ng_i != '0),
                              (nc_i != '0) && (ng_i != '0), nc_i != '0);
        accept_c  = (state_q == IDLE) && !busy && start_i;

        case (state_q)
            RD_G:    sec_field_c = 2'd1;
            RD_A:    sec_field_c = 2'd2;
            RD_B:    sec_field_c = 2'd3;
            default: sec_field_c = 2'd0;
        endcase

        case (rd_field_q)
            2'd1:    in_data_c = G_rdata;
            2'd2:    in_data_c = A_rdata;
            2'd3:    in_data_c = b_rdata;
            default: in_data_c = c_rdata;
        endcase

        state_n = state_q;
        r_n     = r_q;
        k_n     = k_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_n = (first_c == DRAIN) ? IDLE : first_c;
                    r_n     = '0;
                    k_n     = '0;
                end
            end
            RD_C, RD_G, RD_A, RD_B: begin
                if (issue_c) begin
                    if (sec_end_c) begin
                        state_n = nxt_sec_c;
                        r_n     = '0;
                        k_n     = '0;
                    end else if (row_end_c) begin
                        r_n = '0;
                        k_n = NG_W'(k_q + 1'b1);
                    end else begin
                        r_n = ROW_W'(r_q + 1'b1);
                    end
                end
            end
            DRAIN: begin
                if (last_hs_c) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            r_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            ng_q       <= '0;
            nc_q       <= '0;
            c_addr     <= '0;
            G_raddr    <= '0;
            G_caddr    <= '0;
            A_raddr    <= '0;
            A_caddr    <= '0;
            b_addr     <= '0;
            rd_q       <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_field_q <= '0;
            buf_cnt_q  <= '0;
            sk_data_q  <= '0;
            sk_field_q <= '0;
            sk_last_q  <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_field    <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q <= state_n;
            r_q     <= r_n;
            k_q     <= k_n;
            // Address registers follow the next read position; idle ports sit at 0.
            c_addr  <= (state_n == RD_C) ? CR_W'(r_n) : '0;
            G_raddr <= (state_n == RD_G) ? CR_W'(r_n) : '0;
            G_caddr <= (state_n == RD_G) ? GC_W'(k_n) : '0;
            A_raddr <= (state_n == RD_A) ? AR_W'(r_n) : '0;
            A_caddr <= (state_n == RD_A) ? GC_W'(k_n) : '0;
            b_addr  <= (state_n == RD_B) ? AR_W'(r_n) : '0;

            if (accept_c) begin
                n_q  <= n_i;
                ng_q <= ng_i;
                nc_q <= nc_i;
            end

            done <= ((state_q == DRAIN) && last_hs_c) || (accept_c && (first_c == DRAIN));
            if (accept_c) begin
                busy <= 1'b1;
            end else if (((state_q == DRAIN) && last_hs_c) || (state_q == IDLE)) begin
                busy <= 1'b0;
            end

            rd_q       <= issue_c;
            rd_field_q <= sec_field_c;
            rd_last_q  <= issue_c && sec_end_c && (nxt_sec_c == DRAIN);

            // Head entry drives the stream; skid entry refills it on pop.
            if (pop_c && buf_cnt_q == 2'd2) begin
                m_data  <= sk_data_q;
                m_field <= sk_field_q;
                m_last  <= sk_last_q;
            end
            if (rd_q) begin
                if (cnt_pop_c == 2'd0) begin
                    m_data  <= in_data_c;
                    m_field <= rd_field_q;
                    m_last  <= rd_last_q;
                end else begin
                    sk_data_q  <= in_data_c;
                    sk_field_q <= rd_field_q;
                    sk_last_q  <= rd_last_q;
                end
            end
            if (buf_cnt_n == 2'd0) m_last <= 1'b0;
            buf_cnt_q <= buf_cnt_n;
            m_valid   <= (buf_cnt_n != 2'd0);
        end
    end

endmodule

// File: tb/tb_czonotope_reader.sv
// Directed bench for czonotope_reader: RAM models return a word encoding
// (field,row,col), and each read-out is checked beat by beat against a model queue.
module tb_czonotope_reader;

    logic        clk_i = 1'b0;
    logic        rstn_i, start_i, m_ready;
    logic [1:0]  n_i;
    logic [3:0]  ng_i, nc_i;
    logic [1:0]  c_addr, G_raddr;
    logic [3:0]  G_caddr, A_raddr, A_caddr, b_addr;
    logic [31:0] c_rdata, G_rdata, A_rdata, b_rdata, m_data;
    logic        m_valid, m_last, busy, done;
    logic [1:0]  m_field;
    int          tests = 0;
    int          fails = 0;

    czonotope_reader dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .n_i(n_i), .ng_i(ng_i), .nc_i(nc_i),
        .c_addr(c_addr), .c_rdata(c_rdata),
        .G_raddr(G_raddr), .G_caddr(G_caddr), .G_rdata(G_rdata),
        .A_raddr(A_raddr), .A_caddr(A_caddr), .A_rdata(A_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_field(m_field), .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] word(input int f, input int r, input int k);
        case (f)
            0:       word = 32'hC000_0000 + 32'(r);
            1:       word = 32'h6000_0000 + 32'(r * 256) + 32'(k);
            2:       word = 32'hA000_0000 + 32'(r * 256) + 32'(k);
            default: word = 32'hB000_0000 + 32'(r);
        endcase
    endfunction

    // One-cycle synchronous-read RAMs whose content is word(field,row,col).
    always @(posedge clk_i) begin
        c_rdata <= word(0, int'(c_addr), 0);
        G_rdata <= word(1, int'(G_raddr), int'(G_caddr));
        A_rdata <= word(2, int'(A_raddr), int'(A_caddr));
        b_rdata <= word(3, int'(b_addr), 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rnd: random m_ready; restart_at: beat index at which a stray start is pulsed;
    // rst_at: beat index at which reset is asserted (-1 disables).
    task automatic run(input int n, input int ng, input int nc, input bit rnd,
                       input int restart_at, input int rst_at);
        logic [31:0] exp_d[$];
        int          exp_f[$];
        int          total, beat, gaps, early_done, stray;
        bit          finished, hold, clr_start;
        logic [31:0] hold_d;
        logic [1:0]  hold_f;
        logic        hold_l;
        beat = 0; gaps = 0; early_done = 0; stray = 0;
        finished = 0; hold = 0; clr_start = 0;
        hold_d = '0; hold_f = '0; hold_l = 1'b0;
        for (int i = 0; i < n; i++) begin exp_d.push_back(word(0, i, 0)); exp_f.push_back(0); end
        for (int k = 0; k < ng; k++)
            for (int r = 0; r < n; r++) begin exp_d.push_back(word(1, r, k)); exp_f.push_back(1); end
        for (int k = 0; k < ng; k++)
            for (int r = 0; r < nc; r++) begin exp_d.push_back(word(2, r, k)); exp_f.push_back(2); end
        for (int i = 0; i < nc; i++) begin exp_d.push_back(word(3, i, 0)); exp_f.push_back(3); end
        total = exp_d.size();

        @(negedge clk_i);
        n_i = 2'(n); ng_i = 4'(ng); nc_i = 4'(nc); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("no_valid_cycle0", 64'(m_valid), 64'd0);
        if (total == 0) begin
            chk("empty_done_pulse", 64'(done), 64'd1);
            @(negedge clk_i);
            chk("empty_done_cleared", 64'(done), 64'd0);
            chk("empty_busy_one_cycle", 64'(busy), 64'd0);
            chk("empty_no_valid", 64'(m_valid), 64'd0);
            return;
        end
        chk("done_low_at_start", 64'(done), 64'd0);

        for (int cyc = 1; cyc < 2000; cyc++) begin
            @(negedge clk_i);
            if (clr_start) begin start_i = 1'b0; clr_start = 0; end
            if (cyc == 1) chk("valid_latency_c1", 64'(m_valid), 64'd0);
            if (cyc == 2) chk("valid_latency_c2", 64'(m_valid), 64'd1);
            if (rst_at >= 0 && beat == rst_at && m_valid) begin
                rstn_i = 1'b0;
                #1;
                chk("rst_valid_low", 64'(m_valid), 64'd0);
                chk("rst_busy_low", 64'(busy), 64'd0);
                chk("rst_addrs_zero", {44'd0, c_addr, G_raddr, G_caddr, A_raddr, A_caddr, b_addr}, 64'd0);
                @(negedge clk_i);
                rstn_i = 1'b1;
                @(negedge clk_i);
                chk("post_rst_idle", {62'd0, busy, m_valid}, 64'd0);
                finished = 1;
                break;
            end
            if (hold) chk("stall_hold", {29'd0, m_valid, m_last, m_field, m_data},
                          {29'd0, 1'b1, hold_l, hold_f, hold_d});
            if (done) early_done++;
            if ((n == 0 || ng == 0) && (G_raddr != '0 || G_caddr != '0)) stray++;
            if ((nc == 0 || ng == 0) && (A_raddr != '0 || A_caddr != '0)) stray++;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid) begin
                hold   = !m_ready;
                hold_d = m_data; hold_f = m_field; hold_l = m_last;
                if (m_ready) begin
                    chk("beat_data", 64'(m_data), 64'(exp_d[beat]));
                    chk("beat_field", 64'(m_field), 64'(exp_f[beat]));
                    chk("beat_last", 64'(m_last), 64'(beat == total - 1));
                    if (beat == restart_at) begin
                        start_i = 1'b1; n_i = 2'd3; ng_i = 4'd0; nc_i = 4'd0;
                        clr_start = 1;
                    end
                    beat++;
                end
            end else begin
                hold = 0;
                if (cyc >= 2) gaps++;
            end
            if (beat == total) begin
                @(negedge clk_i);
                if (clr_start) begin start_i = 1'b0; clr_start = 0; end
                chk("done_after_last", 64'(done), 64'd1);
                chk("busy_fall_after_last", 64'(busy), 64'd0);
                chk("no_valid_after_last", 64'(m_valid), 64'd0);
                @(negedge clk_i);
                chk("done_one_cycle", 64'(done), 64'd0);
                chk("idle_after_done", {62'd0, busy, m_valid}, 64'd0);
                finished = 1;
                break;
            end
        end
        if (!finished) chk("timeout", 64'd0, 64'd1);
        if (rst_at < 0) begin
            chk("beat_count", 64'(beat), 64'(total));
            chk("no_early_done", 64'(early_done), 64'd0);
            chk("no_stray_addr", 64'(stray), 64'd0);
            if (!rnd) chk("no_bubbles", 64'(gaps), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; m_ready = 1'b0;
        n_i = '0; ng_i = '0; nc_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_flags", {60'd0, m_valid, m_last, busy, done}, 64'd0);
        chk("reset_data_field", {30'd0, m_field, m_data}, 64'd0);
        chk("reset_addrs", {44'd0, c_addr, G_raddr, G_caddr, A_raddr, A_caddr, b_addr}, 64'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset", {62'd0, busy, m_valid}, 64'd0);

        run(2, 3, 1, 1'b0, -1, -1);
        run(2, 3, 1, 1'b1, -1, -1);
        run(3, 0, 2, 1'b0, -1, -1);
        run(0, 0, 0, 1'b0, -1, -1);
        run(2, 3, 1, 1'b0, 3, -1);
        run(2, 3, 1, 1'b0, -1, 5);
        run(2, 3, 1, 1'b0, -1, -1);
        run(0, 4, 3, 1'b1, -1, -1);
        run(1, 1, 0, 1'b0, -1, -1);
        run(3, 15, 12, 1'b1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
